tmds_channel_decoder: RTL and testbench

Receive-side counterpart of the per-channel TMDS encoder in the HDMI video path. Takes one channel's raw 10-bit words from an upstream deserializer (arbitrary, unknown bit rotation), finds word alignment using DVI control tokens, and decodes each aligned word into 8-bit video data, 2-bit control data and a data-enable. Three instances (R, G, B) sit between the deserializer and the downstream video sink; the blue instance recovers hsync/vsync on its `cd` output.

---
 rtl/tmds_pkg.sv | 52 +++++
 rtl/tmds_channel_decoder_if.sv | 29 ++
 rtl/tmds_word_aligner.sv | 45 ++++
 rtl/tmds_channel_decoder.sv | 139 +++++++++++++
 tb/tb_tmds_channel_decoder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: DVI control tokens, receiver FSM states and the
// 10b->8b data decode, so encoder and decoder benches agree on one source.
package tmds_pkg;

    localparam logic [9:0] TOK_CD00 = 10'h354;
    localparam logic [9:0] TOK_CD01 = 10'h0AB;
    localparam logic [9:0] TOK_CD10 = 10'h154;
    localparam logic [9:0] TOK_CD11 = 10'h2AB;

    localparam logic [3:0] OFFSET_MAX = 4'd9;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } dec_state_e;

    typedef struct packed {
        logic       is_tok;
        logic [1:0] cd;
    } tok_info_t;

    function automatic tok_info_t tmds_token(input logic [9:0] w);
        tok_info_t t;
        t.is_tok = 1'b1;
        t.cd     = 2'b00;
        case (w)
            TOK_CD00: t.cd = 2'b00;
            TOK_CD01: t.cd = 2'b01;
            TOK_CD10: t.cd = 2'b10;
            TOK_CD11: t.cd = 2'b11;
            default:  t.is_tok = 1'b0;
        endcase
        return t;
    endfunction

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] v;
        q    = w[9] ? ~w[7:0] : w[7:0];
        v[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            v[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return v;
    endfunction

    function automatic logic [3:0] next_offset(input logic [3:0] o);
        return (o >= OFFSET_MAX) ? 4'd0 : o + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// One TMDS channel between deserializer (master) and decoder (slave).
interface tmds_channel_decoder_if;

    logic [9:0] tmds_in;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    logic       locked;
    logic [3:0] offset;

    modport master (
        output tmds_in,
        input  vd,
        input  cd,
        input  vde,
        input  locked,
        input  offset
    );

    modport slave (
        input  tmds_in,
        output vd,
        output cd,
        output vde,
        output locked,
        output offset
    );

endinterface

// File: rtl/tmds_word_aligner.sv
// Barrel-selects a 10-bit word out of the current and previous raw words at
// the requested bit offset and registers it.
module tmds_word_aligner (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] tmds_i,
    input  logic [3:0] offset_i,
    output logic [9:0] word_o
);

    logic [9:0]  prev_q;
    logic [9:0]  word_q;
    logic [9:0]  word_d;
    logic [18:0] window;
    logic [9:0]  cand [10];

    // The top bit of the new word is never needed: offset 9 reaches bit 18.
    assign window = {tmds_i[8:0], prev_q};

    for (genvar gi = 0; gi < 10; gi++) begin : g_cand
        assign cand[gi] = window[gi+9:gi];
    end

    always_comb begin
        word_d = cand[0];
        for (int i = 1; i < 10; i++) begin
            if (offset_i == 4'(i)) begin
                word_d = cand[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            word_q <= '0;
        end else begin
            prev_q <= tmds_i;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/tmds_channel_decoder.sv
// Per-channel TMDS receiver: hunts for word alignment on DVI control tokens,
// holds lock while tokens keep arriving, and decodes video/control words.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int TOKEN_RUN      = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOSS_TIMEOUT   = 65536
) (
    input  logic                   clk,
    input  logic                   rst,
    tmds_channel_decoder_if.slave  bus
);

    localparam int TOK_W  = $clog2(TOKEN_RUN) + 1;
    localparam int SRCH_W = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

    localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(TOKEN_RUN - 1);
    localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_TIMEOUT - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

    dec_state_e        state_q, state_d;
    logic [3:0]        offset_q, offset_d;
    logic [TOK_W-1:0]  tok_cnt_q, tok_cnt_d;
    logic [SRCH_W-1:0] srch_cnt_q, srch_cnt_d;
    logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
    logic [7:0]        vd_q, vd_d;
    logic [1:0]        cd_q, cd_d;
    logic              vde_q, vde_d;

    logic [9:0]        word;
    tok_info_t         tok;

    tmds_word_aligner u_aligner (
        .clk      (clk),
        .rst      (rst),
        .tmds_i   (bus.tmds_in),
        .offset_i (offset_q),
        .word_o   (word)
    );

    assign tok = tmds_token(word);

    // Counters compare against threshold-1 so each event fires on the edge
    // where the count would reach the threshold, keeping them saturated.
    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        tok_cnt_d  = tok_cnt_q;
        srch_cnt_d = srch_cnt_q;
        loss_cnt_d = loss_cnt_q;

        case (state_q)
            ST_SEARCH: begin
                if (tok.is_tok) begin
                    srch_cnt_d = '0;
                    if (tok_cnt_q == TOK_LAST) begin
                        state_d   = ST_LOCKED;
                        tok_cnt_d = '0;
                    end else begin
                        tok_cnt_d = tok_cnt_q + 1'b1;
                    end
                end else begin
                    tok_cnt_d = '0;
                    if (srch_cnt_q == SRCH_LAST) begin
                        offset_d   = next_offset(offset_q);
                        srch_cnt_d = '0;
                    end else begin
                        srch_cnt_d = srch_cnt_q + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (tok.is_tok) begin
                    loss_cnt_d = '0;
                end else if (loss_cnt_q == LOSS_LAST) begin
                    state_d    = ST_SEARCH;
                    offset_d   = next_offset(offset_q);
                    tok_cnt_d  = '0;
                    srch_cnt_d = '0;
                    loss_cnt_d = '0;
                end else begin
                    loss_cnt_d = loss_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // Outputs follow the state being entered, so they agree with locked on
    // the very edge lock is gained or lost.
    always_comb begin
        vd_d  = '0;
        cd_d  = cd_q;
        vde_d = 1'b0;
        if (state_d == ST_LOCKED) begin
            if (tok.is_tok) begin
                cd_d = tok.cd;
            end else begin
                vde_d = 1'b1;
                vd_d  = tmds_decode(word);
            end
        end else begin
            cd_d = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SEARCH;
            offset_q   <= '0;
            tok_cnt_q  <= '0;
            srch_cnt_q <= '0;
            loss_cnt_q <= '0;
            vd_q       <= '0;
            cd_q       <= '0;
            vde_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            tok_cnt_q  <= tok_cnt_d;
            srch_cnt_q <= srch_cnt_d;
            loss_cnt_q <= loss_cnt_d;
            vd_q       <= vd_d;
            cd_q       <= cd_d;
            vde_q      <= vde_d;
        end
    end

    assign bus.vd     = vd_q;
    assign bus.cd     = cd_q;
    assign bus.vde    = vde_q;
    assign bus.locked = (state_q == ST_LOCKED);
    assign bus.offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder with shortened timeouts; a 3-deep
// expectation queue lines each driven word up with its decoded output.
module tb_tmds_channel_decoder;

    localparam int TR = 8;
    localparam int ST = 32;
    localparam int LT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tmds_channel_decoder_if bus ();

    tmds_channel_decoder #(
        .TOKEN_RUN      (TR),
        .SEARCH_TIMEOUT (ST),
        .LOSS_TIMEOUT   (LT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         tests    = 0;
    int         fails    = 0;
    int         tx_rot   = 0;
    logic [9:0] prev_enc = '0;
    bit         ok;

    typedef struct {
        bit         en;
        logic [7:0] vd;
        logic [1:0] cd;
        logic       vde;
        logic       lk;
        logic [3:0] off;
        string      tag;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Transmit-side reference: stage-1 transition minimisation plus a
    // caller-chosen inversion, which is all the decoder has to undo.
    function automatic logic [9:0] enc(input logic [7:0] d, input bit inv);
        int         n;
        bit         use_xnor;
        logic [8:0] qm;
        n        = $countones(d);
        use_xnor = (n > 4) || (n == 4 && d[0] == 1'b0);
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    endfunction

    task automatic send(input logic [9:0] e, input bit en, input logic [7:0] vd,
                        input logic [1:0] cd, input logic vde, input logic lk,
                        input logic [3:0] off, input string tag);
        exp_t        x;
        logic [19:0] win;
        @(negedge clk);
        if (sb.size() == 3) begin
            x = sb.pop_front();
            if (x.en) begin
                $display("[TB] %s vd=%02h cd=%0d vde=%0b locked=%0b offset=%0d",
                         x.tag, bus.vd, bus.cd, bus.vde, bus.locked, bus.offset);
                chk({x.tag, ".vd"},     32'(bus.vd),     32'(x.vd));
                chk({x.tag, ".cd"},     32'(bus.cd),     32'(x.cd));
                chk({x.tag, ".vde"},    32'(bus.vde),    32'(x.vde));
                chk({x.tag, ".locked"}, 32'(bus.locked), 32'(x.lk));
                chk({x.tag, ".offset"}, 32'(bus.offset), 32'(x.off));
            end
        end
        win         = {e, prev_enc};
        bus.tmds_in = win[(10 - tx_rot) +: 10];
        prev_enc    = e;
        x.en  = en;
        x.vd  = vd;
        x.cd  = cd;
        x.vde = vde;
        x.lk  = lk;
        x.off = off;
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic sendx(input logic [9:0] e);
        send(e, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, "");
    endtask

    task automatic drain();
        repeat (3) sendx(10'h354);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.tmds_in = '0;
        @(negedge clk);
        rst         = 1'b0;
        sb.delete();
        prev_enc    = '0;
    endtask

    // Repeating {24 video, 16 tokens} burst; bounded wait for lock.
    task automatic hunt_lock(output bit got);
        got = 1'b0;
        for (int i = 0; i < 1200 && !got; i++) begin
            sendx(((i % 40) < 24) ? 10'h100 : 10'h354);
            if (bus.locked === 1'b1) got = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random input
        bus.tmds_in = 10'($urandom);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst.vd", 32'(bus.vd), 32'h0);
            chk("rst.cd", 32'(bus.cd), 32'h0);
            chk("rst.vde", 32'(bus.vde), 32'h0);
            chk("rst.locked", 32'(bus.locked), 32'h0);
            chk("rst.offset", 32'(bus.offset), 32'h0);
            bus.tmds_in = 10'($urandom);
        end
        rst         = 1'b0;
        bus.tmds_in = '0;
        @(negedge clk);
        chk("post_rst.locked", 32'(bus.locked), 32'h0);
        chk("post_rst.vde", 32'(bus.vde), 32'h0);
        chk("post_rst.offset", 32'(bus.offset), 32'h0);

        // Aligned lock: 7th token still searching, 8th locks
        for (int i = 0; i < 6; i++) sendx(10'h354);
        send(10'h354, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, "lock_tok7");
        send(10'h354, 1'b1, 8'h00, 2'b00, 1'b0, 1'b1, 4'd0, "lock_tok8");

        // Video decode and ramp round-trip
        send(10'h100, 1'b1, 8'h00, 2'b00, 1'b1, 1'b1, 4'd0, "vid_100");
        send(10'h2FF, 1'b1, 8'hFE, 2'b00, 1'b1, 1'b1, 4'd0, "vid_2ff");
        for (int b = 0; b < 256; b++) begin
            if (b % 32 == 0) send(10'h154, 1'b1, 8'h00, 2'b10, 1'b0, 1'b1, 4'd0, $sformatf("ramp_tok%0d", b));
            send(enc(8'(b), b[0]), 1'b1, 8'(b), 2'b10, 1'b1, 1'b1, 4'd0, $sformatf("ramp%0d", b));
        end

        // Loss of lock: token on final count keeps lock; next full run drops it
        send(10'h2AB, 1'b1, 8'h00, 2'b11, 1'b0, 1'b1, 4'd0, "loss_tok");
        for (int i = 0; i < LT - 2; i++) sendx(10'h100);
        send(10'h100, 1'b1, 8'h00, 2'b11, 1'b1, 1'b1, 4'd0, "loss_63a");
        send(10'h2AB, 1'b1, 8'h00, 2'b11, 1'b0, 1'b1, 4'd0, "loss_keep");
        for (int i = 0; i < LT - 2; i++) sendx(10'h100);
        send(10'h100, 1'b1, 8'h00, 2'b11, 1'b1, 1'b1, 4'd0, "loss_63b");
        send(10'h100, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 4'd1, "loss_drop");
        drain();

        // Rotated lock at offset 3, then all control tokens
        do_reset();
        tx_rot = 3;
        hunt_lock(ok);
        chk("rot3.locked", 32'(ok), 32'h1);
        chk("rot3.offset", 32'(bus.offset), 32'h3);
        send(10'h0AB, 1'b1, 8'h00, 2'b01, 1'b0, 1'b1, 4'd3, "rot_tok01");
        send(10'h154, 1'b1, 8'h00, 2'b10, 1'b0, 1'b1, 4'd3, "rot_tok10");
        send(10'h2AB, 1'b1, 8'h00, 2'b11, 1'b0, 1'b1, 4'd3, "rot_tok11");
        send(10'h2FF, 1'b1, 8'hFE, 2'b11, 1'b1, 1'b1, 4'd3, "rot_vid");
        drain();

        // Mid-operation reset while locked at offset 5
        do_reset();
        tx_rot = 5;
        hunt_lock(ok);
        chk("rot5.locked", 32'(ok), 32'h1);
        chk("rot5.offset", 32'(bus.offset), 32'h5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        bus.tmds_in = '0;
        chk("midrst.locked", 32'(bus.locked), 32'h0);
        chk("midrst.offset", 32'(bus.offset), 32'h0);
        chk("midrst.vde", 32'(bus.vde), 32'h0);
        sb.delete();
        tx_rot   = 0;
        prev_enc = '0;
        for (int i = 0; i < 6; i++) sendx(10'h354);
        send(10'h354, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0, "relock_tok7");
        send(10'h354, 1'b1, 8'h00, 2'b00, 1'b0, 1'b1, 4'd0, "relock_tok8");
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
